icache_linefill_responder: RTL
==============================

Name: icache_linefill_responder

Overview:
- Downstream responder for the icache MSHR miss path.
- Accepts line-fill requests (line address plus MSHR entry index as txnid) and reads the line from the memory side as a burst of beats.
- Assembles the beats into one full line and returns it to the MSHR file with the originating index as the line-fill ack.
- Sits between the MSHR file's downstream request port and the L2/memory read port. It keeps one memory burst outstanding and queues further requests in a small FIFO.

Parameters:
- ADDR_WIDTH, 32: request and memory address width.
- TXNID_WIDTH, 7: MSHR entry index width carried as the transaction id.
- LINE_BYTES, 64: cache line size; power of two.
- BEAT_BYTES, 16: memory data beat size; power of two, ≤ LINE_BYTES. BEATS = LINE_BYTES/BEAT_BYTES.
- REQ_FIFO_DEPTH, 4: request queue depth; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-high (1 = reset).
- txreq_vld  in  1  line-fill request valid.
- txreq_rdy  out  1  request accepted when vld&rdy.
- txreq_addr  in  ADDR_WIDTH  request address; may be unaligned.
- txreq_txnid  in  TXNID_WIDTH  MSHR entry index.
- mem_rd_vld  out  1  memory burst read request.
- mem_rd_rdy  in  1  memory accepts request.
- mem_rd_addr  out  ADDR_WIDTH  line-aligned burst address.
- mem_rdata_vld  in  1  data beat valid; no backpressure.
- mem_rdata  in  BEAT_BYTES*8  beat data.
- mem_rdata_last  in  1  final beat marker.
- linefill_vld  out  1  assembled line valid.
- linefill_rdy  in  1  MSHR/data array accepts line.
- linefill_txnid  out  TXNID_WIDTH  ack index (originating MSHR entry).
- linefill_addr  out  ADDR_WIDTH  line-aligned address.
- linefill_data  out  LINE_BYTES*8  full line; beat 0 in the LSBs.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - FIFO empty, FSM to IDLE, beat counter 0, proto_err 0.
  - All outputs 0. txreq_rdy is 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards the in-flight line and all queued requests.
- Request FIFO:
  - txreq_rdy = !fifo_full, decoded from registered state only; no bypass.
  - A push on vld&rdy stores {addr with low log2(LINE_BYTES) bits zeroed, txnid}.
  - Push and pop in the same cycle are both allowed. Occupancy stays constant; pointers wrap modulo REQ_FIFO_DEPTH.
- FSM IDLE:
  - If the FIFO is not empty: pop the head into the current-request registers, go to ISSUE.
- FSM ISSUE:
  - mem_rd_vld=1, mem_rd_addr = current addr, both held stable until mem_rd_rdy.
  - On vld&rdy: beat counter = 0, go to COLLECT.
- FSM COLLECT:
  - Each mem_rdata_vld writes mem_rdata into the line buffer slice [cnt*BEAT_BYTES*8 +: BEAT_BYTES*8], then cnt+1.
  - On the beat with cnt==BEATS-1: go to RESP.
  - If mem_rdata_last disagrees with (cnt==BEATS-1), set proto_err. Completion is decided by the count alone.
- FSM RESP:
  - linefill_vld=1 with txnid/addr/data held stable until linefill_rdy.
  - On handshake: go to IDLE.
- Latency:
  - Request accepted at edge E → popped at edge E+1 (if IDLE) → mem_rd_vld high in the cycle after E+1.
  - Last beat captured at edge L → linefill_vld high in the cycle after L.
  - Linefill handshake → IDLE for one cycle before the next ISSUE. Minimum turnaround IDLE→ISSUE→…→RESP→IDLE.
- Exactly one burst is outstanding at any time.
- Response ordering: responses return in request order. linefill_txnid always equals the txnid of the popped request.
- mem_rdata_vld in any state other than COLLECT: beat ignored, proto_err set.
- proto_err clears only on reset.
- Counter widths: beat counter is log2(BEATS) bits, minimum 1. FIFO occupancy is log2(REQ_FIFO_DEPTH)+1 bits.

Test Plan:
1. Single request: addr=0x0000_1234, txnid=5; mem_rd_rdy=1; 4 beats 0xA..,0xB..,0xC..,0xD.. with last on beat 3 → mem_rd_addr=0x0000_1200; linefill_txnid=5, linefill_addr=0x0000_1200; data[127:0]=beat0 and data[511:384]=beat3; proto_err=0.
2. Back-to-back fill: 5 requests with linefill_rdy=0 and memory stalled → first popped; then 4 queued, txreq_rdy=0; the 6th vld is not accepted.
3. Drain in order: release linefill_rdy → responses return with txnids in request order; txreq_rdy=1 once an entry pops; busy=0 after the last response.
4. Backpressure: mem_rd_rdy low for 3 cycles, then linefill_rdy low for 5 cycles → mem_rd_addr and the linefill payload stay stable throughout; exactly one mem_rd and one linefill handshake each.
5. Protocol errors: last asserted on beat 1 → proto_err=1 and the line still completes after 4 beats. A stray mem_rdata_vld in IDLE → proto_err stays 1 and no output changes.
6. Reset mid-burst: rst_n=1 during COLLECT after 2 beats with 2 requests queued → next cycle all outputs 0, busy=0; a new request afterwards completes normally with proto_err=0.

Source files
------------

// File: rtl/icache_linefill_responder.sv
// icache_linefill_responder
//
// Purpose: downstream responder on the icache MSHR miss path. It accepts
// line-fill requests (line address plus MSHR entry index as txnid) into a
// small FIFO. It issues one memory burst read at a time and assembles the
// returned beats into a full line. It then returns the line to the MSHR file,
// tagged with the originating txnid. Responses leave in request order.
//
// Ports:
//   clk, rst_n        clock; synchronous reset, active-high (1 = reset)
//   txreq_*           line-fill request channel (valid/ready, addr, txnid)
//   mem_rd_*          burst read request to L2/memory (line-aligned address)
//   mem_rdata_*       returned data beats (no backpressure), last marker
//   linefill_*        assembled line response (valid/ready, txnid, addr, data)
//   busy              FSM not idle or request FIFO not empty
//   proto_err         sticky memory-protocol error flag

module icache_linefill_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TXNID_WIDTH    = 7,
    parameter int LINE_BYTES     = 64,
    parameter int BEAT_BYTES     = 16,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      txreq_vld,
    output logic                      txreq_rdy,
    input  logic [ADDR_WIDTH-1:0]     txreq_addr,
    input  logic [TXNID_WIDTH-1:0]    txreq_txnid,
    output logic                      mem_rd_vld,
    input  logic                      mem_rd_rdy,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic                      mem_rdata_vld,
    input  logic [BEAT_BYTES*8-1:0]   mem_rdata,
    input  logic                      mem_rdata_last,
    output logic                      linefill_vld,
    input  logic                      linefill_rdy,
    output logic [TXNID_WIDTH-1:0]    linefill_txnid,
    output logic [ADDR_WIDTH-1:0]     linefill_addr,
    output logic [LINE_BYTES*8-1:0]   linefill_data,
    output logic                      busy,
    output logic                      proto_err
);

    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = BEAT_BYTES * 8;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [OCC_W-1:0]      FULL_OCC  = OCC_W'(REQ_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COLLECT = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    state_e                  state_q, state_d;

    // Request FIFO: storage is not reset, only pointers and occupancy.
    logic [ADDR_WIDTH-1:0]   fifo_addr_q  [REQ_FIFO_DEPTH];
    logic [TXNID_WIDTH-1:0]  fifo_txnid_q [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]        occ_q;
    logic                    rdy_en_q;

    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [TXNID_WIDTH-1:0]  cur_txnid_q;
    logic [LINE_W-1:0]       line_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic                    proto_err_q;

    logic fifo_full, fifo_empty, push, pop, beat_last;

    assign fifo_full  = (occ_q == FULL_OCC);
    assign fifo_empty = (occ_q == '0);
    // rdy_en_q keeps txreq_rdy low while reset is held and for the reset cycle.
    assign txreq_rdy  = rdy_en_q & ~fifo_full;
    assign push       = txreq_vld & txreq_rdy;
    assign beat_last  = (beat_cnt_q == LAST_CNT);

    // Next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        mem_rd_vld   = 1'b0;
        linefill_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_rd_vld = 1'b1;
                if (mem_rd_rdy) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                // Completion is decided by the beat count alone.
                if (mem_rdata_vld && beat_last) state_d = S_RESP;
            end
            S_RESP: begin
                linefill_vld = 1'b1;
                if (linefill_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rdy_en_q    <= 1'b0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
            if (state_q == S_ISSUE && mem_rd_rdy)
                beat_cnt_q <= '0;
            else if (state_q == S_COLLECT && mem_rdata_vld)
                beat_cnt_q <= beat_cnt_q + 1'b1;
            // Stray beats outside COLLECT, or a last marker that disagrees
            // with the beat count, are flagged but otherwise ignored.
            if (mem_rdata_vld &&
                ((state_q != S_COLLECT) || (mem_rdata_last != beat_last)))
                proto_err_q <= 1'b1;
        end
    end

    // Data registers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= txreq_addr & LINE_MASK;
            fifo_txnid_q[wr_ptr_q] <= txreq_txnid;
        end
        if (pop) begin
            cur_addr_q  <= fifo_addr_q[rd_ptr_q];
            cur_txnid_q <= fifo_txnid_q[rd_ptr_q];
        end
        if (state_q == S_COLLECT && mem_rdata_vld) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_cnt_q == CNT_W'(i)) line_q[i*BEAT_W +: BEAT_W] <= mem_rdata;
            end
        end
    end

    // Payloads are forced to zero outside their valid states so that the
    // unreset data registers never show up on the outputs.
    assign mem_rd_addr    = (state_q == S_ISSUE) ? cur_addr_q  : '0;
    assign linefill_txnid = (state_q == S_RESP)  ? cur_txnid_q : '0;
    assign linefill_addr  = (state_q == S_RESP)  ? cur_addr_q  : '0;
    assign linefill_data  = (state_q == S_RESP)  ? line_q      : '0;
    assign busy           = (state_q != S_IDLE) | ~fifo_empty;
    assign proto_err      = proto_err_q;

endmodule
